cpu_inta_sequencer: RTL and testbench

- CPU-side counterpart of the 8259A-style interrupt controller in the PIC project.
- Samples the controller's INT request and, when interrupts are enabled, drives the two-pulse active-low INTA acknowledge sequence.
- Captures the 8-bit vector the controller places on the data bus during the second pulse and offers it to downstream CPU logic over a valid/ready handshake.
- Serves as the bench-side and system-side initiator that exercises the controller's acknowledge and vector path.

---
 rtl/cpu_inta_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_inta_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_inta_sequencer.sv
// CPU-side interrupt acknowledge sequencer: issues the two-pulse INTA handshake to an
// 8259A-style controller and hands the captured vector downstream over valid/ready.
module cpu_inta_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intr,
  input  logic       if_enable,
  input  logic [7:0] data_bus,
  output logic       inta_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PULSE1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_PULSE2 = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Out-of-range parameters are clamped into the 4-bit counter's usable range.
  function automatic logic [3:0] reload_val(input int cycles);
    if (cycles < 1) begin
      return 4'd0;
    end else if (cycles > 15) begin
      return 4'd14;
    end else begin
      return 4'(cycles - 1);
    end
  endfunction

  localparam logic [3:0] LOW_RELOAD = reload_val(INTA_LOW_CYCLES);
  localparam logic [3:0] GAP_RELOAD = reload_val(INTA_GAP_CYCLES);

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic       r_inta_n;
  logic [7:0] r_vector;
  logic       r_vector_valid;
  logic       r_busy;

  logic [2:0] w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_capture;
  logic       w_cnt_done;

  // Next-state and counter reload logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_capture    = 1'b0;
    w_cnt_done   = (r_cnt == 4'd0);
    case (r_state)
      ST_IDLE: begin
        if (intr && if_enable) begin
          w_next_state = ST_PULSE1;
          w_next_cnt   = LOW_RELOAD;
        end else begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 4'd0;
        end
      end
      ST_PULSE1: begin
        if (w_cnt_done) begin
          w_next_state = ST_GAP;
          w_next_cnt   = GAP_RELOAD;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      ST_GAP: begin
        if (w_cnt_done) begin
          w_next_state = ST_PULSE2;
          w_next_cnt   = LOW_RELOAD;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      ST_PULSE2: begin
        if (w_cnt_done) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = 4'd0;
          w_capture    = 1'b1;
        end else begin
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (vector_ready) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = ST_HOLD;
          w_next_cnt   = 4'd0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the next state so they
  // line up exactly with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 4'd0;
      r_inta_n       <= 1'b1;
      r_vector       <= 8'h00;
      r_vector_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_inta_n       <= !((w_next_state == ST_PULSE1) || (w_next_state == ST_PULSE2));
      r_vector_valid <= (w_next_state == ST_HOLD);
      r_busy         <= (w_next_state != ST_IDLE);
      if (w_capture) begin
        r_vector <= data_bus;
      end else begin
        r_vector <= r_vector;
      end
    end
  end

  assign inta_n       = r_inta_n;
  assign vector       = r_vector;
  assign vector_valid = r_vector_valid;
  assign busy         = r_busy;

  cpu_inta_sequencer_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .inta_n       (r_inta_n),
    .vector       (r_vector),
    .vector_valid (r_vector_valid),
    .vector_ready (vector_ready),
    .busy         (r_busy)
  );

endmodule

// Protocol invariants of the sequencer outputs.
module cpu_inta_sequencer_chk (
  input logic       clk,
  input logic       reset,
  input logic       inta_n,
  input logic [7:0] vector,
  input logic       vector_valid,
  input logic       vector_ready,
  input logic       busy
);

  a_inta_busy: assert property (@(posedge clk) disable iff (reset) !inta_n |-> busy);
  a_valid_busy: assert property (@(posedge clk) disable iff (reset) vector_valid |-> busy);
  a_valid_inta: assert property (@(posedge clk) disable iff (reset) vector_valid |-> inta_n);
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (vector_valid && !vector_ready) |=> (vector_valid && $stable(vector)));

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Scoreboard bench: expected vectors are queued by stimulus and popped by per-DUT
// handshake monitors; INTA timing is checked cycle by cycle against hand-derived patterns.
module tb_cpu_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       intr = 1'b0;
  logic       if_enable = 1'b0;
  logic [7:0] data_bus = 8'h00;
  logic       vector_ready = 1'b0;
  logic       inta_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       busy;

  logic       intr2 = 1'b0;
  logic       en2 = 1'b1;
  logic [7:0] data2 = 8'h00;
  logic       ready2 = 1'b0;
  logic       inta_n2;
  logic [7:0] vector2;
  logic       vector_valid2;
  logic       busy2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  cpu_inta_sequencer dut (
    .clk(clk), .reset(reset), .intr(intr), .if_enable(if_enable), .data_bus(data_bus),
    .inta_n(inta_n), .vector(vector), .vector_valid(vector_valid),
    .vector_ready(vector_ready), .busy(busy)
  );

  cpu_inta_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .intr(intr2), .if_enable(en2), .data_bus(data2),
    .inta_n(inta_n2), .vector(vector2), .vector_valid(vector_valid2),
    .vector_ready(ready2), .busy(busy2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check(name, 8'(busy), 8'h00);
  endtask

  // Handshake monitors: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && vector_valid && vector_ready) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb1_unexpected: got %h, expected no handshake", vector);
      end else begin
        check("sb1_vector", vector, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && vector_valid2 && ready2) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb2_unexpected: got %h, expected no handshake", vector2);
      end else begin
        check("sb2_vector", vector2, q2.pop_front());
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_inta_n", 8'(inta_n), 8'h01);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_valid", 8'(vector_valid), 8'h00);
    check("rst_vector", vector, 8'h00);
    reset = 1'b0;
    tick();

    // Basic sequence with defaults.
    if_enable = 1'b1;
    intr = 1'b1;
    q1.push_back(8'h4A);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) intr = 1'b0;
      data_bus = (k == 5 || k == 6) ? 8'h4A : 8'h00;
      check("t1_inta_n", 8'(inta_n), (k == 1 || k == 2 || k == 5 || k == 6) ? 8'h00 : 8'h01);
    end
    check("t1_valid", 8'(vector_valid), 8'h01);
    check("t1_vector", vector, 8'h4A);
    vector_ready = 1'b1;
    tick();
    vector_ready = 1'b0;
    check("t1_busy_after", 8'(busy), 8'h00);
    check("t1_valid_after", 8'(vector_valid), 8'h00);

    // Interrupts disabled: request must be ignored.
    if_enable = 1'b0;
    intr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t2_inta_n_dis", 8'(inta_n), 8'h01);
      check("t2_busy_dis", 8'(busy), 8'h00);
    end
    if_enable = 1'b1;
    tick();
    intr = 1'b0;
    data_bus = 8'h33;
    check("t2_pulse1_start", 8'(inta_n), 8'h00);
    q1.push_back(8'h33);
    vector_ready = 1'b1;
    wait_idle("t2_idle", 20);
    vector_ready = 1'b0;
    tick();

    // Backpressure: vector frozen while downstream stalls.
    intr = 1'b1;
    data_bus = 8'h0F;
    for (int k = 1; k <= 7; k++) begin
      tick();
      intr = 1'b0;
    end
    check("t3_valid", 8'(vector_valid), 8'h01);
    check("t3_vector", vector, 8'h0F);
    data_bus = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold_valid", 8'(vector_valid), 8'h01);
      check("t3_hold_vector", vector, 8'h0F);
    end
    q1.push_back(8'h0F);
    vector_ready = 1'b1;
    tick();
    vector_ready = 1'b0;
    check("t3_valid_after", 8'(vector_valid), 8'h00);
    check("t3_busy_after", 8'(busy), 8'h00);
    tick();

    // Reset in the first PULSE2 cycle, then a fresh sequence.
    intr = 1'b1;
    data_bus = 8'h00;
    for (int k = 1; k <= 5; k++) tick();
    check("t4_in_pulse2", 8'(inta_n), 8'h00);
    reset = 1'b1;
    tick();
    check("t4_rst_inta_n", 8'(inta_n), 8'h01);
    check("t4_rst_valid", 8'(vector_valid), 8'h00);
    check("t4_rst_vector", vector, 8'h00);
    check("t4_rst_busy", 8'(busy), 8'h00);
    reset = 1'b0;
    tick();
    check("t4_restart_inta", 8'(inta_n), 8'h00);
    check("t4_restart_busy", 8'(busy), 8'h01);
    intr = 1'b0;
    data_bus = 8'hA5;
    q1.push_back(8'hA5);
    vector_ready = 1'b1;
    wait_idle("t4_idle", 20);
    vector_ready = 1'b0;
    tick();

    // intr drops during GAP: spurious vector still captured.
    intr = 1'b1;
    data_bus = 8'h0F;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 3) intr = 1'b0;
      check("t5_inta_n", 8'(inta_n), (k == 1 || k == 2 || k == 5 || k == 6) ? 8'h00 : 8'h01);
    end
    check("t5_valid", 8'(vector_valid), 8'h01);
    check("t5_vector", vector, 8'h0F);
    q1.push_back(8'h0F);
    vector_ready = 1'b1;
    tick();
    vector_ready = 1'b0;
    check("t5_idle", 8'(busy), 8'h00);

    // Short pulses, long gap, intr held high: back-to-back sequences.
    intr2 = 1'b1;
    ready2 = 1'b1;
    data2 = 8'h21;
    q2.push_back(8'h21);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 7) begin
        data2 = 8'h22;
        q2.push_back(8'h22);
      end
      if (k == 9) intr2 = 1'b0;
      check("t6_inta_n", 8'(inta_n2), (k == 1 || k == 5 || k == 8 || k == 12) ? 8'h00 : 8'h01);
      check("t6_valid", 8'(vector_valid2), (k == 6 || k == 13) ? 8'h01 : 8'h00);
      check("t6_busy", 8'(busy2), (k == 7 || k == 14) ? 8'h00 : 8'h01);
    end
    ready2 = 1'b0;
    tick();
    tick();

    check("sb1_drained", 8'(q1.size()), 8'h00);
    check("sb2_drained", 8'(q2.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
